// File: rtl/bcd_pkg.sv
// bcd_pkg: packed-BCD digit type and elaboration-time helpers shared by the BCD counter.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    function automatic logic [31:0] to_bcd(int value, int digits);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction
    function automatic logic bcd_valid(logic [31:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > BCD_MAX_DIGIT) return 1'b0;
        end
        return 1'b1;
    endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: request/status bundle between gate logic and the BCD occupancy counter.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  inc;
    logic                  dec;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic                  load_err;
    modport master (
        output inc, dec, clr, load, load_value,
        input  count_bcd, full, empty, overflow, underflow, load_err
    );
    modport slave (
        input  inc, dec, clr, load, load_value,
        output count_bcd, full, empty, overflow, underflow, load_err
    );
endinterface

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one decimal digit of the +1/-1 ripple; i_cin is carry (up) or borrow (down).
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_cin,
    output bcd_digit_t o_digit,
    output logic       o_cout
);
    logic w_roll;
    assign w_roll  = i_cin & (i_up ? (i_digit == BCD_MAX_DIGIT) : (i_down & (i_digit == 4'd0)));
    assign o_cout  = w_roll;
    assign o_digit = !i_cin ? i_digit :
                     i_up   ? (w_roll ? 4'd0 : i_digit + 4'd1) :
                     i_down ? (w_roll ? BCD_MAX_DIGIT : i_digit - 4'd1) : i_digit;
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit packed-BCD occupancy counter with saturate/wrap at CAPACITY,
// validated load, clear and one-cycle overflow/underflow/load_err pulses.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CAPACITY = 9999,
    parameter bit WRAP     = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    bcd_updown_counter_if.slave bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] CAP_BCD = W'(to_bcd(CAPACITY, DIGITS));

    if (DIGITS < 1 || DIGITS > 8 || CAPACITY < 1 || CAPACITY > 10**DIGITS - 1) begin : g_bad_param
        $error("bcd_updown_counter: DIGITS/CAPACITY out of range");
    end

    logic [W-1:0]  r_count;
    logic          r_ov;
    logic          r_un;
    logic          r_le;
    logic [W-1:0]  w_next;
    logic [W-1:0]  w_step;
    logic [DIGITS:0] w_cy;
    logic          w_up;
    logic          w_dn;
    logic          w_at_cap;
    logic          w_zero;
    logic          w_load_ok;
    logic          w_ov;
    logic          w_un;
    logic          w_le;
    logic          w_unused;

    // inc and dec together cancel, so the chain only ever sees one direction
    assign w_up      = bus.inc & ~bus.dec;
    assign w_dn      = bus.dec & ~bus.inc;
    assign w_at_cap  = r_count == CAP_BCD;
    assign w_zero    = r_count == '0;
    assign w_load_ok = bcd_valid(32'(bus.load_value)) && (bus.load_value <= CAP_BCD);
    assign w_cy[0]   = 1'b1;
    assign w_unused  = w_cy[DIGITS];

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit_step u_step (
            .i_digit (r_count[4*d +: 4]),
            .i_up    (w_up),
            .i_down  (w_dn),
            .i_cin   (w_cy[d]),
            .o_digit (w_step[4*d +: 4]),
            .o_cout  (w_cy[d+1])
        );
    end

    always_comb begin
        w_next = r_count;
        w_ov   = 1'b0;
        w_un   = 1'b0;
        w_le   = 1'b0;
        if (bus.clr) begin
            w_next = '0;
        end else if (bus.load) begin
            w_next = w_load_ok ? bus.load_value : r_count;
            w_le   = !w_load_ok;
        end else if (w_up) begin
            w_next = w_at_cap ? (WRAP ? '0 : r_count) : w_step;
            w_ov   = w_at_cap;
        end else if (w_dn) begin
            w_next = w_zero ? (WRAP ? CAP_BCD : r_count) : w_step;
            w_un   = w_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ov    <= 1'b0;
            r_un    <= 1'b0;
            r_le    <= 1'b0;
        end else begin
            r_count <= w_next;
            r_ov    <= w_ov;
            r_un    <= w_un;
            r_le    <= w_le;
        end
    end

    assign bus.count_bcd = r_count;
    assign bus.full      = w_at_cap;
    assign bus.empty     = w_zero;
    assign bus.overflow  = r_ov;
    assign bus.underflow = r_un;
    assign bus.load_err  = r_le;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed vectors on three configurations (4-digit/9999, 2-digit/25 saturate,
// 2-digit/25 wrap); stimulus queues expected state, a negedge monitor pops and compares.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(4)) if4 ();
    bcd_updown_counter_if #(.DIGITS(2)) ifs ();
    bcd_updown_counter_if #(.DIGITS(2)) ifw ();

    bcd_updown_counter #(.DIGITS(4), .CAPACITY(9999), .WRAP(1'b0)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    bcd_updown_counter #(.DIGITS(2), .CAPACITY(25),   .WRAP(1'b0)) us (.clk(clk), .rst(rst), .bus(ifs.slave));
    bcd_updown_counter #(.DIGITS(2), .CAPACITY(25),   .WRAP(1'b1)) uw (.clk(clk), .rst(rst), .bus(ifw.slave));

    typedef struct {
        int          u;
        string       nm;
        logic [15:0] c;
        logic [4:0]  f;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // flags packed as {full, empty, overflow, underflow, load_err}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_FULL = 5'b10000;
    localparam logic [4:0] F_EMP  = 5'b01000;
    localparam logic [4:0] F_OV   = 5'b00100;
    localparam logic [4:0] F_UN   = 5'b00010;
    localparam logic [4:0] F_LE   = 5'b00001;

    task automatic step(input int u, input bit r, input bit i, input bit d, input bit c, input bit l,
                        input logic [15:0] lv, input string nm, input logic [15:0] ec, input logic [4:0] ef);
        exp_t e;
        rst = r;
        if4.inc = (u == 0) && i; if4.dec = (u == 0) && d; if4.clr = (u == 0) && c; if4.load = (u == 0) && l;
        ifs.inc = (u == 1) && i; ifs.dec = (u == 1) && d; ifs.clr = (u == 1) && c; ifs.load = (u == 1) && l;
        ifw.inc = (u == 2) && i; ifw.dec = (u == 2) && d; ifw.clr = (u == 2) && c; ifw.load = (u == 2) && l;
        if4.load_value = lv;
        ifs.load_value = lv[7:0];
        ifw.load_value = lv[7:0];
        @(posedge clk);
        #1;
        e.u = u; e.nm = nm; e.c = ec; e.f = ef;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [20:0] act;
            e = q.pop_front();
            case (e.u)
                0:       act = {if4.count_bcd, if4.full, if4.empty, if4.overflow, if4.underflow, if4.load_err};
                1:       act = {8'h00, ifs.count_bcd, ifs.full, ifs.empty, ifs.overflow, ifs.underflow, ifs.load_err};
                default: act = {8'h00, ifw.count_bcd, ifw.full, ifw.empty, ifw.overflow, ifw.underflow, ifw.load_err};
            endcase
            checks++;
            if (act !== {e.c, e.f}) begin
                failures++;
                $display("FAIL %s: count=%h flags(f,e,ov,un,le)=%b required count=%h flags=%b",
                         e.nm, act[20:5], act[4:0], e.c, e.f);
            end
        end
    end

    initial begin
        step(0, 1, 0, 0, 0, 0, 16'h0, "rst4", 16'h0000, F_EMP);
        step(1, 1, 0, 0, 0, 0, 16'h0, "rst_sat", 16'h0000, F_EMP);
        step(2, 1, 0, 0, 0, 0, 16'h0, "rst_wrap", 16'h0000, F_EMP);
        for (int k = 1; k <= 10; k++)
            step(0, 0, 1, 0, 0, 0, 16'h0, $sformatf("inc%0d", k), (k == 10) ? 16'h0010 : 16'(k), F_NONE);
        step(0, 0, 0, 1, 0, 0, 16'h0,    "dec_to_9",     16'h0009, F_NONE);
        step(0, 0, 0, 0, 0, 1, 16'h0999, "load_0999",    16'h0999, F_NONE);
        step(0, 0, 1, 0, 0, 0, 16'h0,    "carry_1000",   16'h1000, F_NONE);
        step(0, 0, 0, 1, 0, 0, 16'h0,    "borrow_0999",  16'h0999, F_NONE);
        step(0, 0, 0, 0, 0, 1, 16'h9999, "load_9999",    16'h9999, F_FULL);
        step(0, 0, 1, 0, 0, 0, 16'h0,    "sat4_ov",      16'h9999, F_FULL | F_OV);
        step(0, 0, 0, 0, 0, 0, 16'h0,    "sat4_ov_drop", 16'h9999, F_FULL);
        step(0, 0, 0, 0, 1, 0, 16'h0,    "clr4",         16'h0000, F_EMP);
        step(0, 0, 0, 1, 0, 0, 16'h0,    "sat4_un",      16'h0000, F_EMP | F_UN);
        step(0, 0, 1, 1, 0, 0, 16'h0,    "incdec_at0",   16'h0000, F_EMP);
        step(0, 0, 0, 0, 0, 1, 16'hA000, "load4_bad",    16'h0000, F_EMP | F_LE);
        step(1, 0, 0, 0, 0, 1, 16'h0025, "sat_load25",   16'h0025, F_FULL);
        step(1, 0, 1, 0, 0, 0, 16'h0,    "sat_ov",       16'h0025, F_FULL | F_OV);
        step(1, 0, 0, 0, 0, 0, 16'h0,    "sat_ov_drop",  16'h0025, F_FULL);
        step(1, 0, 0, 0, 1, 0, 16'h0,    "sat_clr",      16'h0000, F_EMP);
        step(1, 0, 0, 1, 0, 0, 16'h0,    "sat_un",       16'h0000, F_EMP | F_UN);
        step(1, 0, 0, 0, 0, 0, 16'h0,    "sat_un_drop",  16'h0000, F_EMP);
        step(1, 0, 0, 0, 0, 1, 16'h003A, "load_3A",      16'h0000, F_EMP | F_LE);
        step(1, 0, 0, 0, 0, 1, 16'h0026, "load_26",      16'h0000, F_EMP | F_LE);
        step(1, 0, 0, 0, 0, 1, 16'h0019, "load_19",      16'h0019, F_NONE);
        step(1, 0, 1, 1, 0, 0, 16'h0,    "incdec_hold",  16'h0019, F_NONE);
        step(1, 0, 1, 0, 0, 1, 16'h0010, "load_w_inc",   16'h0010, F_NONE);
        step(1, 0, 0, 1, 0, 0, 16'h0,    "sat_dec_09",   16'h0009, F_NONE);
        step(1, 0, 0, 1, 1, 1, 16'h0022, "clr_w_load",   16'h0000, F_EMP);
        step(2, 0, 0, 0, 0, 1, 16'h0025, "wrap_load25",  16'h0025, F_FULL);
        step(2, 0, 1, 0, 0, 0, 16'h0,    "wrap_ov",      16'h0000, F_EMP | F_OV);
        step(2, 0, 0, 1, 0, 0, 16'h0,    "wrap_un",      16'h0025, F_FULL | F_UN);
        step(2, 0, 0, 0, 0, 0, 16'h0,    "wrap_idle",    16'h0025, F_FULL);
        step(2, 0, 0, 0, 0, 1, 16'h0024, "wrap_load24",  16'h0024, F_NONE);
        step(2, 0, 1, 0, 0, 0, 16'h0,    "wrap_inc25",   16'h0025, F_FULL);
        step(2, 0, 1, 0, 0, 0, 16'h0,    "wrap_ov2",     16'h0000, F_EMP | F_OV);
        step(2, 0, 0, 0, 0, 1, 16'h0025, "wrap_reload",  16'h0025, F_FULL);
        step(2, 0, 1, 0, 0, 0, 16'h0,    "wrap_ov3",     16'h0000, F_EMP | F_OV);
        step(2, 1, 1, 0, 0, 0, 16'h0,    "rst_mid_ov",   16'h0000, F_EMP);
        step(2, 0, 0, 0, 0, 0, 16'h0,    "post_rst",     16'h0000, F_EMP);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
